// File: rtl/key_pkg.sv
// Shared state encoding and default 50 MHz timing for the key gesture path.
package key_pkg;

    localparam int unsigned CNT_W = 30;

    localparam logic [CNT_W-1:0] LONG_CYC   = 30'd50_000_000;
    localparam logic [CNT_W-1:0] DBL_CYC    = 30'd15_000_000;
    localparam logic [CNT_W-1:0] REPEAT_CYC = 30'd5_000_000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_e;

endpackage

// File: rtl/key_edge.sv
// Registers the debounced key level and flags its falling (press) and rising (release) edges.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_lvl,
    output logic key_r,
    output logic fall,
    output logic rise
);

    logic r_key;

    // Reset to "released" so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key <= 1'b1;
        end else begin
            r_key <= key_lvl;
        end
    end

    assign key_r = r_key;
    assign fall  = r_key & ~key_lvl;
    assign rise  = ~r_key & key_lvl;

endmodule

// File: rtl/key_gesture.sv
// Classifies debounced key activity into short, long, double-click and auto-repeat pulses.
module key_gesture #(
    parameter int unsigned      CNT_W      = key_pkg::CNT_W,
    parameter logic [CNT_W-1:0] LONG_CYC   = key_pkg::LONG_CYC,
    parameter logic [CNT_W-1:0] DBL_CYC    = key_pkg::DBL_CYC,
    parameter logic [CNT_W-1:0] REPEAT_CYC = key_pkg::REPEAT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic key_lvl,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse
);

    import key_pkg::*;

    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYC - CNT_W'(1);
    localparam logic [CNT_W-1:0] DBL_LAST  = DBL_CYC - CNT_W'(1);
    localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_CYC - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             w_key_r;
    logic             w_fall;
    logic             w_rise;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_clr;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_dbl_nxt;
    logic             w_rep_nxt;
    logic             r_short;
    logic             r_long;
    logic             r_dbl;
    logic             r_rep;

    key_edge u_key_edge (
        .clk     (clk),
        .rst     (rst),
        .key_lvl (key_lvl),
        .key_r   (w_key_r),
        .fall    (w_fall),
        .rise    (w_rise)
    );

    // Edge events take priority over coincident timeouts in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        w_dbl_nxt   = 1'b0;
        w_rep_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = PRESS1;
            end
            PRESS1: begin
                if (w_rise) begin
                    w_state_nxt = WAIT2;
                end else if (r_cnt == LONG_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = LONG_HOLD;
                end
            end
            WAIT2: begin
                if (w_fall) begin
                    w_dbl_nxt   = 1'b1;
                    w_state_nxt = PRESS2;
                end else if (r_cnt == DBL_LAST) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            PRESS2: begin
                if (w_rise) w_state_nxt = IDLE;
            end
            LONG_HOLD: begin
                if (w_rise) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == REP_LAST) begin
                    w_rep_nxt = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt != r_state) w_cnt_clr = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_dbl   <= 1'b0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Saturate in states without a timeout so an idle counter never wraps.
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
            r_dbl   <= w_dbl_nxt;
            r_rep   <= w_rep_nxt;
        end
    end

    assign pressed      = ~w_key_r;
    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign double_pulse = r_dbl;
    assign repeat_pulse = r_rep;

endmodule
